// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and master FSM state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } master_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one cmd in, one AXI transaction, one rsp beat out.
// Latency: zero-wait slave gives cmd accept at edge N, rsp_valid from cycle N+3 (4-cycle minimum turnaround).
// Backpressure: cmd_ready only in IDLE; rsp_* held stable until rsp_ready; AXI valids held until handshake.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command stream (wdata/wstrb ignored for reads)
//   rsp_valid/ready/write/rdata/resp         response stream (rdata forced to 0 for writes)
//   aw*, w*, b*, ar*, r*          AXI4-Lite master channels; awprot/arprot tied to PROT
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,

    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    master_state_t r_state;

    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_araddr;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;

    logic w_aw_fire;
    logic w_w_fire;
    logic w_aw_complete;
    logic w_w_complete;

    assign w_aw_fire     = r_awvalid & awready;
    assign w_w_fire      = r_wvalid & wready;
    // A channel counts as complete if it finished earlier or is finishing on this edge.
    assign w_aw_complete = r_aw_done | w_aw_fire;
    assign w_w_complete  = r_w_done  | w_w_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_araddr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            r_awaddr    <= cmd_addr;
                            r_wdata     <= cmd_wdata;
                            r_wstrb     <= cmd_wstrb;
                            r_awvalid   <= 1'b1;
                            r_wvalid    <= 1'b1;
                            r_aw_done   <= 1'b0;
                            r_w_done    <= 1'b0;
                            r_rsp_write <= 1'b1;
                            r_state     <= ST_WR_REQ;
                        end else begin
                            r_araddr    <= cmd_addr;
                            r_arvalid   <= 1'b1;
                            r_rsp_write <= 1'b0;
                            r_state     <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_complete && w_w_complete) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_RD_REQ: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_RESP;
                    end
                end

                ST_RD_RESP: begin
                    if (rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= rresp;
                        r_rsp_rdata <= rdata;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign awprot    = PROT;
    assign arprot    = PROT;

    assign awaddr    = r_awaddr;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign araddr    = r_araddr;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a behavioural AXI4-Lite slave and a response scoreboard.
// Latency: checks the zero-wait N+1 / N+3 timing and stalled-channel behaviour.
// Backpressure: drives rsp_ready low to exercise response hold and command blocking.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    axi4_lite_master #(.PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int          aw_wait = 0;
    int          w_wait  = 0;
    int          aw_cnt  = 0;
    int          w_cnt   = 0;
    bit          aw_got  = 0;
    bit          w_got   = 0;
    bit          ar_got  = 0;
    bit          b_pend  = 0;
    bit          r_pend  = 0;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [logic [31:0]];

    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0; ar_got = 0;
            b_pend = 0; r_pend = 0;
        end else begin
            // B channel: response only after both AW and W have handshaken.
            if (b_pend) begin
                bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0;
            end else if (aw_got && w_got && !bvalid) begin
                bvalid = 1;
                if (s_awaddr == 32'h0000_FFF0) begin
                    bresp = RESP_DECERR;
                end else begin
                    logic [31:0] cur;
                    bresp = RESP_OKAY;
                    cur = mem.exists(s_awaddr) ? mem[s_awaddr] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) cur[b*8 +: 8] = s_wdata[b*8 +: 8];
                    mem[s_awaddr] = cur;
                end
            end
            if (bvalid && bready) b_pend = 1;

            // R channel
            if (r_pend) begin
                rvalid = 0; r_pend = 0; ar_got = 0;
            end else if (ar_got && !rvalid) begin
                rvalid = 1;
                if (s_araddr == 32'h0000_FFFC) begin
                    rresp = RESP_SLVERR;
                    rdata = 32'h0BAD_F00D;
                end else begin
                    rresp = RESP_OKAY;
                    rdata = mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
                end
            end
            if (rvalid && rready) r_pend = 1;

            // Address/data channels: ready pulses once, after the configured wait.
            awready = 0;
            if (awvalid && !aw_got) begin
                if (aw_cnt >= aw_wait) begin
                    awready = 1; aw_got = 1; aw_cnt = 0; s_awaddr = awaddr;
                end else aw_cnt++;
            end
            wready = 0;
            if (wvalid && !w_got) begin
                if (w_cnt >= w_wait) begin
                    wready = 1; w_got = 1; w_cnt = 0; s_wdata = wdata; s_wstrb = wstrb;
                end else w_cnt++;
            end
            arready = 0;
            if (arvalid && !ar_got) begin
                arready = 1; ar_got = 1; s_araddr = araddr;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];
    int   rsp_cnt = 0;
    bit   hold_prev = 0;
    logic        h_write;
    logic [31:0] h_rdata;
    logic [1:0]  h_resp;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                chk("rsp_write stable", {31'b0, rsp_write}, {31'b0, h_write});
                chk("rsp_rdata stable", rsp_rdata, h_rdata);
                chk("rsp_resp stable", {30'b0, rsp_resp}, {30'b0, h_resp});
            end
            hold_prev = rsp_valid && !rsp_ready;
            h_write = rsp_write; h_rdata = rsp_rdata; h_resp = rsp_resp;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected response", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_write", {31'b0, rsp_write}, {31'b0, e.w});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
                end
                rsp_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] dat,
                         input logic [3:0] strb, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_resp, output int waited);
        exp_t e;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = dat; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            chk("cmd accept timeout", 32'h1, 32'h0);
            cmd_valid = 1'b0;
        end else begin
            e.w = wr; e.rdata = exp_rdata; e.resp = exp_resp;
            exp_q.push_back(e);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("response count", rsp_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        int nrsp = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset awvalid", {31'b0, awvalid}, 32'h0);
        chk("reset wvalid",  {31'b0, wvalid},  32'h0);
        chk("reset arvalid", {31'b0, arvalid}, 32'h0);
        chk("reset bready",  {31'b0, bready},  32'h0);
        chk("reset rready",  {31'b0, rready},  32'h0);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset awaddr", awaddr, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset cmd_ready (IDLE)", {31'b0, cmd_ready}, 32'h1);
        chk("awprot", {29'b0, awprot}, 32'h0);
        chk("arprot", {29'b0, arprot}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. Zero-wait write 0x10 <= 0xDEADBEEF
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, RESP_OKAY, w);
        chk("wr N+1 awvalid", {31'b0, awvalid}, 32'h1);
        chk("wr N+1 wvalid",  {31'b0, wvalid},  32'h1);
        chk("wr N+1 awaddr", awaddr, 32'h10);
        chk("wr N+1 wdata", wdata, 32'hDEAD_BEEF);
        chk("wr N+1 wstrb", {28'b0, wstrb}, 32'hF);
        chk("wr N+1 cmd_ready", {31'b0, cmd_ready}, 32'h0);
        @(posedge clk); #1;
        chk("wr N+2 awvalid", {31'b0, awvalid}, 32'h0);
        chk("wr N+2 wvalid",  {31'b0, wvalid},  32'h0);
        chk("wr N+2 bready",  {31'b0, bready},  32'h1);
        chk("wr N+2 rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        chk("wr N+3 rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("wr N+3 bready", {31'b0, bready}, 32'h0);
        wait_rsp(++nrsp);

        // 2. W delayed 3 cycles behind AW
        w_wait = 3;
        issue(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, RESP_OKAY, w);
        chk("dly awvalid", {31'b0, awvalid}, 32'h1);
        chk("dly wvalid",  {31'b0, wvalid},  32'h1);
        @(posedge clk); #1;
        chk("dly awvalid dropped", {31'b0, awvalid}, 32'h0);
        cnt = 0;
        while (wvalid && cnt < 20) begin
            chk("dly wdata stable", wdata, 32'h1234_5678);
            chk("dly bready low", {31'b0, bready}, 32'h0);
            @(posedge clk); #1;
            cnt++;
        end
        chk("dly wvalid extra cycles", cnt, 32'd3);
        chk("dly bready after W", {31'b0, bready}, 32'h1);
        wait_rsp(++nrsp);
        w_wait = 0;

        // 3. Read back 0x10
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY, w);
        chk("rd N+1 arvalid", {31'b0, arvalid}, 32'h1);
        chk("rd N+1 araddr", araddr, 32'h10);
        chk("rd N+1 rready", {31'b0, rready}, 32'h0);
        @(posedge clk); #1;
        chk("rd N+2 arvalid", {31'b0, arvalid}, 32'h0);
        chk("rd N+2 rready", {31'b0, rready}, 32'h1);
        @(posedge clk); #1;
        chk("rd N+3 rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("rd N+3 rready", {31'b0, rready}, 32'h0);
        wait_rsp(++nrsp);

        // 4. Response backpressure, then back-to-back command
        rsp_ready = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, RESP_OKAY, w);
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp rsp_valid held", {31'b0, rsp_valid}, 32'h1);
            chk("bp cmd_ready low", {31'b0, cmd_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp cmd_ready after consume", {31'b0, cmd_ready}, 32'h1);
        issue(1'b1, 32'h30, 32'hAABB_CCDD, 4'h3, 32'h0, RESP_OKAY, w);
        chk("b2b accepted without wait", w, 32'd0);
        nrsp += 2;
        wait_rsp(nrsp);
        issue(1'b0, 32'h30, 32'h0, 4'h0, 32'h0000_CCDD, RESP_OKAY, w);
        wait_rsp(++nrsp);

        // 5. Error responses pass through
        issue(1'b0, 32'hFFFC, 32'h0, 4'h0, 32'h0BAD_F00D, RESP_SLVERR, w);
        wait_rsp(++nrsp);
        issue(1'b1, 32'hFFF0, 32'h5555_5555, 4'hF, 32'h0, RESP_DECERR, w);
        wait_rsp(++nrsp);

        // 6. Reset while AW and W are both stalled
        aw_wait = 20; w_wait = 20;
        issue(1'b1, 32'h40, 32'h0F0F_0F0F, 4'hF, 32'h0, RESP_OKAY, w);
        @(posedge clk); #1;
        chk("pre-rst awvalid", {31'b0, awvalid}, 32'h1);
        chk("pre-rst wvalid",  {31'b0, wvalid},  32'h1);
        rst = 1'b1;
        #1;
        chk("rst awvalid", {31'b0, awvalid}, 32'h0);
        chk("rst wvalid",  {31'b0, wvalid},  32'h0);
        chk("rst arvalid", {31'b0, arvalid}, 32'h0);
        chk("rst bready",  {31'b0, bready},  32'h0);
        chk("rst rready",  {31'b0, rready},  32'h0);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst IDLE", {31'b0, cmd_ready}, 32'h1);
        exp_q.delete();
        aw_wait = 0; w_wait = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst cmd_ready", {31'b0, cmd_ready}, 32'h1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY, w);
        wait_rsp(++nrsp);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Converts a simple valid/ready command stream (read or write) into AXI4-Lite channel handshakes.
- Returns one response beat per command.
- Drives register-mapped slaves such as the LSTM layer block: weight loading, control writes and status/result readback from a sequencer or test harness.

Parameters:
- PROT, 3'b000, constant value driven on awprot and arprot.

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  32  byte address
- cmd_wdata  input  32  write data; ignored for reads
- cmd_wstrb  input  4  write strobes; ignored for reads
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_write  output  1  echo of cmd_write for this response
- rsp_rdata  output  32  read data; 0 for writes
- rsp_resp  output  2  captured bresp or rresp
- awaddr  output  32  AXI write address
- awprot  output  3
- awvalid  output  1
- awready  input  1
- wdata  output  32
- wstrb  output  4
- wvalid  output  1
- wready  input  1
- bresp  input  2
- bvalid  input  1
- bready  output  1
- araddr  output  32
- arprot  output  3
- arvalid  input/output: output  1
- arready  input  1
- rdata  input  32
- rresp  input  2
- rvalid  input  1
- rready  output  1

Behaviour:
- All outputs registered, except cmd_ready (decode of state == IDLE) and awprot/arprot (constant PROT).
- Reset values: every valid/ready output 0; all address, data, strb and rsp_* outputs 0; state IDLE.
- States and transitions:
  - IDLE → WR_REQ on cmd_valid with cmd_write = 1.
  - IDLE → RD_REQ on cmd_valid with cmd_write = 0.
  - WR_REQ → WR_RESP once both AW and W have handshaken.
  - WR_RESP → RSP on bvalid.
  - RD_REQ → RD_RESP on arready.
  - RD_RESP → RSP on rvalid.
  - RSP → IDLE on rsp_ready.
- Command capture (cmd_valid & cmd_ready at edge N):
  - Address, data and strb are latched.
  - Write: awvalid and wvalid are both 1 from cycle N+1.
  - Read: arvalid is 1 from cycle N+1.
- AW and W channels are independent:
  - Each valid drops in the cycle after its own handshake (valid & ready sampled at the edge).
  - Per-channel done flags track completion.
  - Either order and same-cycle completion are all legal.
- awaddr, wdata, wstrb and araddr are held stable while the corresponding valid is high; valid is never withdrawn before handshake.
- bready is 1 only in WR_RESP; rready is 1 only in RD_RESP.
- bresp/rresp/rdata are captured on the handshake edge; rsp_valid = 1 the next cycle.
- rsp_* fields are held stable while rsp_valid & !rsp_ready.
- Write responses force rsp_rdata = 0.
- Zero-wait slave latency:
  - Write: cmd edge N, AW/W handshake N+1, B handshake N+2, rsp_valid at N+3.
  - Read: cmd N, AR N+1, R N+2, rsp_valid at N+3.
- No new command is accepted until the response is consumed. Throughput is one transaction per 4 cycles minimum.
- SLVERR/DECERR are passed through unmodified. No retry, no timeout.
- Reset mid-operation: immediate return to IDLE with all valids deasserted. The connected slave is reset by the same rst, so no AXI protocol recovery is required.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - Response constants: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - The master state encoding.
- No sub-module; a single FSM module.

Test Plan:
- Zero-wait slave; write addr 0x10, data 0xDEADBEEF, strb 0xF → awvalid and wvalid at N+1; rsp_valid at N+3 with rsp_write = 1, rsp_resp = 0, rsp_rdata = 0.
- wready delayed 3 cycles after awready → awvalid drops after 1 cycle; wvalid held with wdata stable; bready rises only after the W handshake; single response returned.
- Read 0x10 after the write → arvalid at N+1; rready in RD_RESP; rsp_rdata = 0xDEADBEEF, rsp_resp = 0.
- rsp_ready held low 5 cycles → rsp_* stable and cmd_ready = 0 throughout; back-to-back command accepted the cycle after rsp_ready.
- Slave returns rresp = 2'b10 for address 0xFFFC → rsp_resp = 2'b10, rsp_rdata = captured rdata.
- rst asserted while awvalid = 1 and wready stalled → all valids and readies 0 immediately; state IDLE; cmd_ready = 1 after release.
